// File: rtl/seven_segment_mux.sv
// Seven-segment driver: converts a binary value to BCD, shows it on multiplexed digits.
// Ports: clk, rst (sync, high), load/value in, busy/overflow out, seg/an active-low drive.
// Optional blink (SEVSEG_BLINK_EN): BLINK_BIT parameter and blink input blank all digits.
module seven_segment_mux #(
    parameter int DIGITS       = 4,
    parameter int WIDTH        = 14,
    parameter int REFRESH_BITS = 17
`ifdef SEVSEG_BLINK_EN
    ,
    parameter int BLINK_BIT    = 24
`endif
) (
    input  logic              clk,
    input  logic              rst,
`ifdef SEVSEG_BLINK_EN
    input  logic              blink,
`endif
    input  logic              load,
    input  logic [WIDTH-1:0]  value,
    output logic              busy,
    output logic              overflow,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an
);

    // BCD field holds every decimal digit of 2^WIDTH-1 and at least DIGITS digits.
    localparam int NBCD = ((WIDTH / 3 + 1) > DIGITS) ? (WIDTH / 3 + 1) : DIGITS;
    localparam int SW   = 4 * NBCD + WIDTH;
    localparam int CNTW = $clog2(WIDTH + 1);
    localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW   = (WIDTH > 27) ? WIDTH : 27;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    function automatic logic [CW-1:0] pow10(input int n);
        logic [CW-1:0] p;
        p = CW'(1);
        for (int i = 0; i < n; i++) begin
            p = p * CW'(10);
        end
        return p;
    endfunction

    localparam logic [CW-1:0] LIMIT = pow10(DIGITS);

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] s;
        unique case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    typedef enum logic {
        S_IDLE,
        S_CONV
    } state_t;

    state_t                   state_q, state_d;
    logic [SW-1:0]            sr_q, sr_d;
    logic [CNTW-1:0]          cnt_q, cnt_d;
    logic                     ovf_pend_q, ovf_pend_d;
    logic                     ovf_q, ovf_d;
    logic [DIGITS-1:0][6:0]   disp_q, disp_d;
    logic [REFRESH_BITS-1:0]  ref_q, ref_d;
    logic [IW-1:0]            idx_q, idx_d;

    logic [SW-1:0]            sr_adj;
    logic [SW-1:0]            sr_step;
    logic [DIGITS-1:0][6:0]   disp_new;
    logic [3:0]               dig;
    logic                     nz;
    logic [DIGITS-1:0]        an_scan;

    // One double-dabble step: add 3 to every BCD digit >= 5, then shift left.
    always_comb begin
        sr_adj = sr_q;
        for (int k = 0; k < NBCD; k++) begin
            if (sr_q[WIDTH+4*k +: 4] >= 4'd5) begin
                sr_adj[WIDTH+4*k +: 4] = sr_q[WIDTH+4*k +: 4] + 4'd3;
            end
        end
        sr_step = sr_adj << 1;
    end

    // Segment image of the finished conversion; zeros above the top
    // nonzero digit are blanked, digit 0 is always shown.
    always_comb begin
        disp_new = '0;
        dig      = '0;
        nz       = 1'b0;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            dig = sr_step[WIDTH+4*d +: 4];
            nz  = nz | (dig != 4'd0);
            if (ovf_pend_q) begin
                disp_new[d] = SEG_DASH;
            end else if (nz || d == 0) begin
                disp_new[d] = seg_code(dig);
            end else begin
                disp_new[d] = SEG_BLANK;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        ovf_d      = ovf_q;
        disp_d     = disp_q;
        unique case (state_q)
            S_IDLE: begin
                if (load) begin
                    sr_d       = SW'(value);
                    cnt_d      = '0;
                    ovf_pend_d = (CW'(value) >= LIMIT);
                    state_d    = S_CONV;
                end
            end
            S_CONV: begin
                sr_d  = sr_step;
                cnt_d = cnt_q + CNTW'(1);
                if (cnt_q == CNTW'(WIDTH - 1)) begin
                    state_d = S_IDLE;
                    ovf_d   = ovf_pend_q;
                    disp_d  = disp_new;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Scan runs continuously, unaffected by conversion activity.
    always_comb begin
        ref_d = ref_q + REFRESH_BITS'(1);
        idx_d = idx_q;
        if (&ref_q) begin
            idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            sr_q       <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            ovf_q      <= 1'b0;
            disp_q     <= {DIGITS{SEG_BLANK}};
            ref_q      <= '0;
            idx_q      <= '0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            ovf_q      <= ovf_d;
            disp_q     <= disp_d;
            ref_q      <= ref_d;
            idx_q      <= idx_d;
        end
    end

    assign an_scan  = ~(DIGITS'(1) << idx_q);
    assign seg      = disp_q[idx_q];
    assign busy     = (state_q == S_CONV);
    assign overflow = ovf_q;

`ifdef SEVSEG_BLINK_EN
    logic [BLINK_BIT:0] blk_q, blk_d;

    always_comb begin
        blk_d = blk_q + (BLINK_BIT + 1)'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blk_q <= '0;
        end else begin
            blk_q <= blk_d;
        end
    end

    assign an = (blink && blk_q[BLINK_BIT]) ? '1 : an_scan;
`else
    assign an = an_scan;
`endif

endmodule

// File: tb/tb_seven_segment_mux.sv
// Bench for seven_segment_mux: random and directed loads, scoreboard of expected
// displays popped at each conversion end, scan output checked every cycle.
module tb_seven_segment_mux;

    localparam int DIGITS = 4;
    localparam int WIDTH  = 14;
    localparam int RB     = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              load = 1'b0;
    logic [WIDTH-1:0]  value = '0;
    logic              busy;
    logic              overflow;
    logic [6:0]        seg;
    logic [DIGITS-1:0] an;

    seven_segment_mux #(
        .DIGITS(DIGITS),
        .WIDTH(WIDTH),
        .REFRESH_BITS(RB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .load(load),
        .value(value),
        .busy(busy),
        .overflow(overflow),
        .seg(seg),
        .an(an)
    );

    always #5 clk = ~clk;

    typedef struct {
        int v;
        int k;
    } exp_t;

    exp_t        sb[$];
    int          nvec = 0;
    int          nerr = 0;
    int          k = 0;
    logic        busy_prev = 1'b0;
    logic [6:0]  exp_disp[DIGITS];
    logic        exp_ovf = 1'b0;
    logic [6:0]  codes[10] = '{7'b1000000, 7'b1111001, 7'b0100100,
                               7'b0110000, 7'b0011001, 7'b0010010,
                               7'b0000010, 7'b1111000, 7'b0000000,
                               7'b0010000};

    function automatic void chk(string name, int act, int expv);
        nvec++;
        if (act != expv) begin
            nerr++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t",
                     name, act, act, expv, expv, $time);
        end
    endfunction

    function automatic void model_blank();
        for (int d = 0; d < DIGITS; d++) exp_disp[d] = 7'b1111111;
        exp_ovf = 1'b0;
    endfunction

    // Decimal view of the value: digit d = (v / 10^d) % 10.
    function automatic void model_set(int v);
        int p;
        exp_ovf = (v >= 10000);
        p = 1;
        for (int d = 0; d < DIGITS; d++) begin
            if (exp_ovf) exp_disp[d] = 7'b0111111;
            else if (d == 0 || v >= p) exp_disp[d] = codes[(v / p) % 10];
            else exp_disp[d] = 7'b1111111;
            p = p * 10;
        end
    endfunction

    always @(posedge clk) begin
        if (rst) k = 0;
        else k++;
    end

    // Monitor: pops at every falling edge of busy, then checks scan outputs.
    always @(negedge clk) begin
        int   idx;
        exp_t e;
        if (rst) begin
            busy_prev = 1'b0;
        end else begin
            if (busy_prev && !busy) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("busy_len", k - e.k, WIDTH);
                    model_set(e.v);
                end
            end
            busy_prev = busy;
            idx = (k / (1 << RB)) % DIGITS;
            chk("an", int'(an), int'(4'b1111 ^ (4'b1 << idx)));
            chk("seg", int'(seg), int'(exp_disp[idx]));
            chk("overflow", int'(overflow), int'(exp_ovf));
        end
    end

    task automatic do_reset(int n);
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        model_blank();
        repeat (n) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_an", int'(an), 4'b1110);
        chk("rst_seg", int'(seg), 7'b1111111);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic load_val(int v);
        exp_t e;
        @(posedge clk);
        #1;
        load  = 1'b1;
        value = WIDTH'(v);
        if (!busy) begin
            e.v = v;
            e.k = k + 1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || sb.size() != 0) && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (n >= 80) chk("idle_timeout", 1, 0);
    endtask

    int bounds[6] = '{0, 9, 9999, 10000, 16383, 1000};

    initial begin
        int v;
        model_blank();
        do_reset(3);
        repeat (6) @(posedge clk);

        load_val(1234);
        wait_idle();
        repeat (20) @(posedge clk);

        load_val(7);
        wait_idle();
        repeat (16) @(posedge clk);

        load_val(10000);
        wait_idle();
        repeat (16) @(posedge clk);
        load_val(0);
        wait_idle();
        repeat (16) @(posedge clk);

        load_val(42);
        load_val(99);
        wait_idle();
        repeat (16) @(posedge clk);

        load_val(1234);
        repeat (4) @(posedge clk);
        do_reset(1);
        repeat (40) @(posedge clk);

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) == 0) v = bounds[$urandom_range(0, 5)];
            else v = int'($urandom_range(0, 16383));
            load_val(v);
            repeat ($urandom_range(0, 20)) @(posedge clk);
        end
        wait_idle();
        repeat (20) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/seven_segment_mux.md
SEVEN_SEGMENT_MUX -- requirements
Module: seven_segment_mux

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of multiplexed digits (legal 1..8).
REQ-002 SHALL have parameter WIDTH, default 14, bit width of the unsigned binary input value.
REQ-003 SHALL have parameter REFRESH_BITS, default 17; each digit is enabled for 2^REFRESH_BITS cycles.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port load  input  1  request to convert and display value.
REQ-007 SHALL have port value  input  WIDTH  unsigned binary number to display.
REQ-008 SHALL have port busy  output  1  conversion in progress; load ignored while high.
REQ-009 SHALL have port overflow  output  1  displayed value exceeds 10^DIGITS-1.
REQ-010 SHALL have port seg  output  7  segment drive, active-low, bit order {g,f,e,d,c,b,a}.
REQ-011 SHALL have port an  output  DIGITS  digit enable, active-low, one-hot; bit 0 = least significant digit.

Function
REQ-012 Load SHALL be accepted on an edge where load=1 and busy=0; value captured on that edge.
REQ-013 Conversion SHALL be sequential double-dabble: one add-3 plus shift step per cycle, WIDTH steps.
REQ-014 busy SHALL be 1 for exactly WIDTH cycles after the accepting edge; on the edge ending the last step, display digit register and overflow update atomically and busy returns to 0.
REQ-015 load=1 while busy=1 SHALL be ignored with no effect on the conversion in progress or on the display.
REQ-016 Display register SHALL hold its previous contents throughout a conversion.
REQ-017 overflow SHALL be set when captured value >= 10^DIGITS; all digits then show '-' (0111111).
REQ-018 Without overflow, leading zeros SHALL be blanked (1111111); digit 0 always shown, so value 0 displays "0".
REQ-019 Digit encodings SHALL be 0:1000000 1:1111001 2:0100100 3:0110000 4:0011001 5:0010010 6:0000010 7:1111000 8:0000000 9:0010000.
REQ-020 Scan index SHALL advance by one every 2^REFRESH_BITS cycles, wrapping from DIGITS-1 to 0 (non-power-of-two DIGITS included).
REQ-021 an SHALL drive low only the bit at the scan index; seg SHALL be the registered code for that digit, same cycle as an.
REQ-022 Scan timing SHALL be independent of load, busy and conversion.

Reset
REQ-023 On rst: busy=0, overflow=0, conversion aborted, display register all-blank, scan counter and index 0.
REQ-024 During and after reset until first completed conversion: an has bit 0 low, all others high; seg=1111111.
REQ-025 rst SHALL take priority over a simultaneous load.

Configuration
REQ-026 With macro SEVSEG_BLINK_EN defined: parameter BLINK_BIT (default 24) and input port blink (1 bit) SHALL exist; a free-running counter runs from reset; when blink=1 and counter bit BLINK_BIT is 1, an SHALL be all ones; otherwise an per REQ-021.
REQ-027 Without SEVSEG_BLINK_EN: no blink port, no BLINK_BIT parameter, no blink counter; display never blanks for blink.

Verification (DIGITS=4, WIDTH=14, REFRESH_BITS=2)
REQ-028 Assert rst 3 cycles -> busy=0, overflow=0, an=1110, seg=1111111.
REQ-029 load value=1234 one cycle -> busy high 14 cycles; then an 1110/1101/1011/0111 with seg 0011001/0110000/0100100/1111001, each for 4 cycles, repeating.
REQ-030 load value=7 -> digit 0 seg=1111000, digits 1..3 seg=1111111, overflow=0.
REQ-031 load value=10000 -> overflow=1, all four digits seg=0111111; then load value=0 -> overflow=0, digit 0 seg=1000000, others blank.
REQ-032 load value=42, then load value=99 two cycles later -> second ignored, display 42, busy falls 14 cycles after first load.
REQ-033 rst asserted 5 cycles into a conversion of 1234 -> busy=0 next cycle, display blank, no later update; with SEVSEG_BLINK_EN, BLINK_BIT=3, blink=1 -> an all ones 8 of every 16 cycles.
